// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: state codes, state width and
// default timing constants used by the top level and its bench.
package alarm_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

  localparam int DEF_CLK_PER_TICK    = 50000;
  localparam int DEF_EXIT_TICKS      = 10000;
  localparam int DEF_ENTRY_TICKS     = 5000;
  localparam int DEF_ALARM_TICKS     = 60000;
  localparam int DEF_BEEP_HALF_TICKS = 250;
  localparam int DEF_TW              = 16;

endpackage

// File: rtl/alarm_ctrl_tick_prescaler.sv
// Free-running clock prescaler producing a one-cycle tick every CLK_PER_TICK
// cycles; only reset clears it.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt_r;

  // wrap-around cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/alarm_ctrl.sv
// Intrusion alarm arm/disarm sequencer with exit/entry delays and buzzer drive.
// Optional tamper input and forced-alarm path enabled by `define ALARM_TAMPER_EN.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int CLK_PER_TICK    = DEF_CLK_PER_TICK,
  parameter int EXIT_TICKS      = DEF_EXIT_TICKS,
  parameter int ENTRY_TICKS     = DEF_ENTRY_TICKS,
  parameter int ALARM_TICKS     = DEF_ALARM_TICKS,
  parameter int BEEP_HALF_TICKS = DEF_BEEP_HALF_TICKS,
  parameter int TW              = DEF_TW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               motion_ok,
`ifdef ALARM_TAMPER_EN
  input  logic               tamper,
`endif
  output logic               buzzer,
  output logic [STATE_W-1:0] state,
  output logic               armed,
  output logic               alarm_active
);

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_TICKS);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_TICKS);
  localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_TICKS);
  localparam logic [TW-1:0] ONE        = TW'(1);
  localparam logic [TW-1:0] BEEP_LAST  = TW'(BEEP_HALF_TICKS - 1);

  logic          tick_s;
  logic          expire_s;
  state_t        state_r,    state_s;
  logic [TW-1:0] timer_r,    timer_s;
  logic [TW-1:0] beep_cnt_r, beep_cnt_s;
  logic          beep_r,     beep_s;
  logic          buzzer_r,   buzzer_s;
  logic          armed_r,    armed_s;
  logic          alarm_r,    alarm_s;

  tick_prescaler #(
    .CLK_PER_TICK (CLK_PER_TICK)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // a timed state leaves on the tick that finds one tick remaining
  assign expire_s = tick_s && (timer_r == ONE);

  // next-state and timer; disarm outranks everything
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    if (disarm_req) begin
      state_s = ST_DISARMED;
    end
`ifdef ALARM_TAMPER_EN
    else if (tamper) begin
      state_s = ST_ALARM;
      timer_s = ALARM_LOAD;
    end
`endif
    else begin
      case (state_r)
        ST_DISARMED: begin
          if (arm_req) begin
            state_s = ST_EXIT_DELAY;
            timer_s = EXIT_LOAD;
          end else begin
            state_s = ST_DISARMED;
          end
        end
        ST_EXIT_DELAY: begin
          if (expire_s) begin
            state_s = ST_ARMED;
          end else if (tick_s) begin
            timer_s = timer_r - ONE;
          end else begin
            timer_s = timer_r;
          end
        end
        ST_ARMED: begin
          if (motion_ok) begin
            state_s = ST_ENTRY_DELAY;
            timer_s = ENTRY_LOAD;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_ENTRY_DELAY: begin
          if (expire_s) begin
            state_s = ST_ALARM;
            timer_s = ALARM_LOAD;
          end else if (tick_s) begin
            timer_s = timer_r - ONE;
          end else begin
            timer_s = timer_r;
          end
        end
        ST_ALARM: begin
          if (expire_s) begin
            state_s = ST_ARMED;
          end else if (tick_s) begin
            timer_s = timer_r - ONE;
          end else begin
            timer_s = timer_r;
          end
        end
        default: begin
          state_s = ST_DISARMED;
        end
      endcase
    end
  end

  // beep pattern restarts high on every state change, then toggles per half period
  always_comb begin
    beep_cnt_s = beep_cnt_r;
    beep_s     = beep_r;
    if (state_s != state_r) begin
      beep_cnt_s = '0;
      beep_s     = 1'b1;
    end else if (tick_s && (beep_cnt_r == BEEP_LAST)) begin
      beep_cnt_s = '0;
      beep_s     = ~beep_r;
    end else if (tick_s) begin
      beep_cnt_s = beep_cnt_r + ONE;
    end else begin
      beep_cnt_s = beep_cnt_r;
    end
  end

  // output decode from the next state so outputs align with state
  always_comb begin
    buzzer_s = 1'b0;
    armed_s  = 1'b1;
    alarm_s  = 1'b0;
    case (state_s)
      ST_DISARMED:    armed_s  = 1'b0;
      ST_EXIT_DELAY:  buzzer_s = beep_s;
      ST_ARMED:       buzzer_s = 1'b0;
      ST_ENTRY_DELAY: buzzer_s = beep_s;
      ST_ALARM: begin
        buzzer_s = 1'b1;
        alarm_s  = 1'b1;
      end
      default: begin
        armed_s  = 1'b0;
      end
    endcase
  end

  // state, timer, beep and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_DISARMED;
      timer_r    <= '0;
      beep_cnt_r <= '0;
      beep_r     <= 1'b0;
      buzzer_r   <= 1'b0;
      armed_r    <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      beep_cnt_r <= beep_cnt_s;
      beep_r     <= beep_s;
      buzzer_r   <= buzzer_s;
      armed_r    <= armed_s;
      alarm_r    <= alarm_s;
    end
  end

  assign state        = state_r;
  assign buzzer       = buzzer_r;
  assign armed        = armed_r;
  assign alarm_active = alarm_r;

endmodule
